// File: rtl/gshare_pkg.sv
// Shared types and helpers for the multithreaded gshare predictor.
package gshare_pkg;

  typedef enum logic {StInit, StRun} state_e;

  // Weakly-taken value: lowest counter value with the MSB set.
  function automatic int unsigned weak_taken(int unsigned counter_bits);
    return 32'd1 << (counter_bits - 1);
  endfunction

  function automatic int unsigned sat_inc(int unsigned val, int unsigned max_val);
    return (val >= max_val) ? max_val : val + 1;
  endfunction

  function automatic int unsigned sat_dec(int unsigned val);
    return (val == 0) ? 0 : val - 1;
  endfunction

endpackage

// File: rtl/gshare_predictor_mt_ghr.sv
// Per-thread global history register: speculative shift, mispredict repair, reset.
module gshare_ghr
  import gshare_pkg::*;
#(
  parameter int unsigned GHR_SIZE = 8
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_shift_en,
  input  logic                i_shift_bit,
  input  logic                i_repair_en,
  input  logic [GHR_SIZE-1:0] i_repair_ghr,
  output logic [GHR_SIZE-1:0] o_ghr
);

  logic [GHR_SIZE-1:0] ghr_q;

  // Repair beats the speculative shift: the shifted prediction is on the wrong path.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ghr_q <= '0;
    end else if (i_repair_en) begin
      ghr_q <= i_repair_ghr;
    end else if (i_shift_en) begin
      ghr_q <= {ghr_q[GHR_SIZE-2:0], i_shift_bit};
    end
  end

  assign o_ghr = ghr_q;

endmodule

// File: rtl/gshare_predictor_mt.sv
// Multithreaded gshare predictor with per-thread GHR and a post-reset counter sweep.
// Optional per-thread statistics counters are enabled by defining GSHARE_STATS_EN.
module gshare_predictor_mt
  import gshare_pkg::*;
#(
  parameter  int unsigned NUM_THREADS  = 4,
  parameter  int unsigned GHR_SIZE     = 8,
  parameter  int unsigned COUNTER_BITS = 2,
  localparam int unsigned THREAD_W     = $clog2(NUM_THREADS)
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  output logic                      o_ready,
  input  logic                      i_pred_valid,
  input  logic [THREAD_W-1:0]       i_pred_thread,
  input  logic [GHR_SIZE-1:0]       i_pred_pc,
  output logic                      o_pred_taken,
  output logic [GHR_SIZE-1:0]       o_pred_ghr,
  input  logic                      i_res_valid,
  input  logic [THREAD_W-1:0]       i_res_thread,
  input  logic [GHR_SIZE-1:0]       i_res_pc,
  input  logic [GHR_SIZE-1:0]       i_res_ghr,
  input  logic                      i_res_taken,
`ifdef GSHARE_STATS_EN
  output logic [NUM_THREADS*32-1:0] o_stat_pred,
  output logic [NUM_THREADS*32-1:0] o_stat_mispred,
`endif
  input  logic                      i_res_mispredict
);

  localparam int unsigned IDX_W = THREAD_W + GHR_SIZE;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CMAX  = (1 << COUNTER_BITS) - 1;
  localparam int unsigned WEAK  = weak_taken(COUNTER_BITS);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               ready_q;

  logic [COUNTER_BITS-1:0] table_q [DEPTH];
  logic [COUNTER_BITS-1:0] res_cnt_d;
  logic [GHR_SIZE-1:0]     ghr [NUM_THREADS];
  logic [IDX_W-1:0]        pred_idx;
  logic [IDX_W-1:0]        res_idx;
  logic                    pred_acc;
  logic                    res_acc;
  logic [GHR_SIZE-1:0]     repair_ghr;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= StInit;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == IDX_W'(DEPTH - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: ;
        default: state_q <= StInit;
      endcase
    end
  end

  assign pred_acc   = ready_q & i_pred_valid;
  assign res_acc    = ready_q & i_res_valid;
  assign pred_idx   = {i_pred_thread, ghr[i_pred_thread] ^ i_pred_pc};
  assign res_idx    = {i_res_thread, i_res_ghr ^ i_res_pc};
  assign repair_ghr = {i_res_ghr[GHR_SIZE-2:0], i_res_taken};

  always_comb begin
    res_cnt_d = i_res_taken ? COUNTER_BITS'(sat_inc(32'(table_q[res_idx]), CMAX))
                            : COUNTER_BITS'(sat_dec(32'(table_q[res_idx])));
  end

  // No reset on the table: the INIT sweep writes every entry instead.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      if (state_q == StInit) begin
        table_q[ptr_q] <= COUNTER_BITS'(WEAK);
      end else if (res_acc) begin
        table_q[res_idx] <= res_cnt_d;
      end
    end
  end

  // Reads the pre-update table: a same-cycle resolve is not forwarded.
  assign o_pred_taken = ready_q & table_q[pred_idx][COUNTER_BITS-1];
  assign o_pred_ghr   = ready_q ? ghr[i_pred_thread] : '0;
  assign o_ready      = ready_q;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_ghr
    gshare_ghr #(
      .GHR_SIZE(GHR_SIZE)
    ) u_ghr (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_shift_en  (pred_acc && (i_pred_thread == THREAD_W'(t))),
      .i_shift_bit (o_pred_taken),
      .i_repair_en (res_acc && i_res_mispredict && (i_res_thread == THREAD_W'(t))),
      .i_repair_ghr(repair_ghr),
      .o_ghr       (ghr[t])
    );
  end

`ifdef GSHARE_STATS_EN
  logic [31:0] pred_cnt_q    [NUM_THREADS];
  logic [31:0] mispred_cnt_q [NUM_THREADS];

  always_ff @(posedge i_Clk) begin
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (i_Reset) begin
        pred_cnt_q[t]    <= '0;
        mispred_cnt_q[t] <= '0;
      end else begin
        if (pred_acc && (i_pred_thread == THREAD_W'(t)) && (pred_cnt_q[t] != '1)) begin
          pred_cnt_q[t] <= pred_cnt_q[t] + 32'd1;
        end
        if (res_acc && i_res_mispredict && (i_res_thread == THREAD_W'(t)) &&
            (mispred_cnt_q[t] != '1)) begin
          mispred_cnt_q[t] <= mispred_cnt_q[t] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    o_stat_pred    = '0;
    o_stat_mispred = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      o_stat_pred[t*32 +: 32]    = pred_cnt_q[t];
      o_stat_mispred[t*32 +: 32] = mispred_cnt_q[t];
    end
  end
`endif

endmodule

// File: tb/tb_gshare_predictor_mt.sv
// Randomised self-checking bench for gshare_predictor_mt against a behavioural model.
module tb_gshare_predictor_mt;

  localparam int NT      = 2;
  localparam int GS      = 4;
  localparam int CB      = 2;
  localparam int ENTRIES = NT << GS;
  localparam int HALF    = 1 << (CB - 1);
  localparam int CMAXV   = (1 << CB) - 1;
  localparam int MASK    = (1 << GS) - 1;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        o_ready;
  logic        i_pred_valid = 1'b0;
  logic [0:0]  i_pred_thread = '0;
  logic [3:0]  i_pred_pc = '0;
  logic        o_pred_taken;
  logic [3:0]  o_pred_ghr;
  logic        i_res_valid = 1'b0;
  logic [0:0]  i_res_thread = '0;
  logic [3:0]  i_res_pc = '0;
  logic [3:0]  i_res_ghr = '0;
  logic        i_res_taken = 1'b0;
  logic        i_res_mispredict = 1'b0;
`ifdef GSHARE_STATS_EN
  logic [63:0] o_stat_pred;
  logic [63:0] o_stat_mispred;
`endif

  always #5 i_Clk = ~i_Clk;

  gshare_predictor_mt #(
    .NUM_THREADS (NT),
    .GHR_SIZE    (GS),
    .COUNTER_BITS(CB)
  ) dut (
    .i_Clk           (i_Clk),
    .i_Reset         (i_Reset),
    .o_ready         (o_ready),
    .i_pred_valid    (i_pred_valid),
    .i_pred_thread   (i_pred_thread),
    .i_pred_pc       (i_pred_pc),
    .o_pred_taken    (o_pred_taken),
    .o_pred_ghr      (o_pred_ghr),
    .i_res_valid     (i_res_valid),
    .i_res_thread    (i_res_thread),
    .i_res_pc        (i_res_pc),
    .i_res_ghr       (i_res_ghr),
    .i_res_taken     (i_res_taken),
`ifdef GSHARE_STATS_EN
    .o_stat_pred     (o_stat_pred),
    .o_stat_mispred  (o_stat_mispred),
`endif
    .i_res_mispredict(i_res_mispredict)
  );

  int cmp_count  = 0;
  int fail_count = 0;

  // Behavioural model: counters as plain integers, histories as integers.
  int m_cnt [NT][1 << GS];
  int m_ghr [NT];
  bit m_ready = 1'b0;
  int m_init_left = ENTRIES;
`ifdef GSHARE_STATS_EN
  int m_stat_pred [NT];
  int m_stat_mis  [NT];
`endif

  function automatic int exp_ghr(int t);
    return m_ready ? m_ghr[t] : 0;
  endfunction

  function automatic bit exp_taken(int t, int pc);
    return m_ready && (m_cnt[t][(m_ghr[t] ^ pc) & MASK] >= HALF);
  endfunction

  task automatic model_update();
    int  pt, ppc, rt, ridx;
    bit  ptaken, repaired;
    if (i_Reset) begin
      m_ready     = 1'b0;
      m_init_left = ENTRIES;
      for (int t = 0; t < NT; t++) begin
        m_ghr[t] = 0;
`ifdef GSHARE_STATS_EN
        m_stat_pred[t] = 0;
        m_stat_mis[t]  = 0;
`endif
      end
    end else if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_ready = 1'b1;
        for (int t = 0; t < NT; t++)
          for (int i = 0; i < (1 << GS); i++) m_cnt[t][i] = HALF;
      end
    end else begin
      pt       = int'(i_pred_thread);
      ppc      = int'(i_pred_pc);
      rt       = int'(i_res_thread);
      ptaken   = exp_taken(pt, ppc);
      repaired = i_res_valid && i_res_mispredict;
      if (i_res_valid) begin
        ridx = int'(i_res_ghr) ^ int'(i_res_pc);
        if (i_res_taken) begin
          if (m_cnt[rt][ridx] < CMAXV) m_cnt[rt][ridx]++;
        end else begin
          if (m_cnt[rt][ridx] > 0) m_cnt[rt][ridx]--;
        end
        if (i_res_mispredict) begin
          m_ghr[rt] = ((int'(i_res_ghr) << 1) | int'(i_res_taken)) & MASK;
`ifdef GSHARE_STATS_EN
          m_stat_mis[rt]++;
`endif
        end
      end
      if (i_pred_valid) begin
`ifdef GSHARE_STATS_EN
        m_stat_pred[pt]++;
`endif
        if (!(repaired && rt == pt)) m_ghr[pt] = ((m_ghr[pt] << 1) | int'(ptaken)) & MASK;
      end
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    model_update();
    @(negedge i_Clk);
    #1;
  endtask

  task automatic idle();
    i_pred_valid     = 1'b0;
    i_res_valid      = 1'b0;
    i_res_mispredict = 1'b0;
  endtask

  task automatic set_pred(int t, int pc);
    i_pred_valid  = 1'b1;
    i_pred_thread = 1'(t);
    i_pred_pc     = 4'(pc);
  endtask

  task automatic set_res(int t, int ghr, int pc, bit taken, bit mis);
    i_res_valid      = 1'b1;
    i_res_thread     = 1'(t);
    i_res_ghr        = 4'(ghr);
    i_res_pc         = 4'(pc);
    i_res_taken      = taken;
    i_res_mispredict = mis;
  endtask

  task automatic test_reset();
    int n;
    i_Reset = 1'b1;
    idle();
    tick();
    tick();
    set_pred(0, 3);
    #1;
    cmp_count++;
    if (o_ready !== 1'b0) begin
      fail_count++; $display("FAIL reset_ready: got %0b want 0", o_ready);
    end
    cmp_count++;
    if (o_pred_taken !== 1'b0) begin
      fail_count++; $display("FAIL reset_taken: got %0b want 0", o_pred_taken);
    end
    cmp_count++;
    if (o_pred_ghr !== 4'h0) begin
      fail_count++; $display("FAIL reset_ghr: got %0h want 0", o_pred_ghr);
    end
    idle();
    i_Reset = 1'b0;
    n = 0;
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    cmp_count++;
    if (n != ENTRIES) begin
      fail_count++; $display("FAIL sweep_len: got %0d cycles want %0d", n, ENTRIES);
    end
    set_pred(0, 3);
    #1;
    cmp_count++;
    if (o_pred_taken !== 1'b1) begin
      fail_count++; $display("FAIL first_pred: got %0b want 1", o_pred_taken);
    end
    idle();
  endtask

  task automatic test_pred_shift();
    int want [3] = '{0, 1, 3};
    for (int k = 0; k < 3; k++) begin
      set_pred(0, 3);
      #1;
      cmp_count++;
      if (o_pred_ghr !== 4'(want[k])) begin
        fail_count++; $display("FAIL shift_ghr%0d: got %0h want %0h", k, o_pred_ghr, want[k]);
      end
      cmp_count++;
      if (o_pred_taken !== exp_taken(0, 3)) begin
        fail_count++; $display("FAIL shift_taken%0d: got %0b want %0b", k, o_pred_taken,
                               exp_taken(0, 3));
      end
      tick();
    end
    set_pred(0, 3);
    #1;
    cmp_count++;
    if (o_pred_ghr !== 4'h7) begin
      fail_count++; $display("FAIL shift_final: got %0h want 7", o_pred_ghr);
    end
    idle();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      set_res(0, 0, 3, 1'b0, 1'b0);
      tick();
    end
    // Mispredict resolve with snapshot 0 / not-taken clears GHR0 to 0.
    set_res(0, 0, 3, 1'b0, 1'b1);
    tick();
    idle();
    set_pred(0, 3);
    #1;
    cmp_count++;
    if (o_pred_ghr !== 4'h0) begin
      fail_count++; $display("FAIL sat_ghr_repair: got %0h want 0", o_pred_ghr);
    end
    cmp_count++;
    if (o_pred_taken !== 1'b0) begin
      fail_count++; $display("FAIL sat_low: got %0b want 0", o_pred_taken);
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      set_res(0, 0, 3, 1'b1, 1'b0);
      tick();
    end
    idle();
    set_pred(0, 3);
    #1;
    cmp_count++;
    if (o_pred_taken !== 1'b1) begin
      fail_count++; $display("FAIL sat_no_wrap_low: got %0b want 1", o_pred_taken);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      set_res(0, 0, 3, 1'b1, 1'b0);
      tick();
    end
    set_res(0, 0, 3, 1'b0, 1'b0);
    tick();
    idle();
    set_pred(0, 3);
    #1;
    cmp_count++;
    if (o_pred_taken !== 1'b1) begin
      fail_count++; $display("FAIL sat_no_wrap_high: got %0b want 1", o_pred_taken);
    end
    idle();
  endtask

  task automatic test_repair();
    int pc0, want0;
    set_res(1, 7, 0, 1'b1, 1'b1);
    tick();
    idle();
    set_pred(1, 0);
    #1;
    cmp_count++;
    if (o_pred_ghr !== 4'hF) begin
      fail_count++; $display("FAIL repair_setup: got %0h want f", o_pred_ghr);
    end
    set_res(1, 5, 0, 1'b0, 1'b1);
    tick();
    idle();
    set_pred(1, 0);
    #1;
    cmp_count++;
    if (o_pred_ghr !== 4'hA) begin
      fail_count++; $display("FAIL repair_same_thread: got %0h want a", o_pred_ghr);
    end
    idle();
    set_res(1, 7, 0, 1'b1, 1'b1);
    tick();
    pc0   = int'($urandom_range(0, 15));
    want0 = ((m_ghr[0] << 1) | int'(exp_taken(0, pc0))) & MASK;
    set_pred(0, pc0);
    set_res(1, 5, 0, 1'b0, 1'b1);
    tick();
    idle();
    set_pred(1, 0);
    #1;
    cmp_count++;
    if (o_pred_ghr !== 4'hA) begin
      fail_count++; $display("FAIL repair_other_t1: got %0h want a", o_pred_ghr);
    end
    tick();
    set_pred(0, 0);
    #1;
    cmp_count++;
    if (o_pred_ghr !== 4'(want0)) begin
      fail_count++; $display("FAIL repair_other_t0: got %0h want %0h", o_pred_ghr, want0);
    end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int n;
    int bad;
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    cmp_count++;
    if (o_ready !== 1'b0) begin
      fail_count++; $display("FAIL midinit_ready: got %0b want 0", o_ready);
    end
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    n   = 0;
    bad = 0;
    while (!o_ready && n < 100) begin
      set_pred(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      set_res(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      #1;
      if (o_pred_taken !== 1'b0 || o_pred_ghr !== 4'h0) bad++;
      tick();
      n++;
    end
    idle();
    cmp_count++;
    if (bad != 0) begin
      fail_count++; $display("FAIL init_outputs: got %0d nonzero cycles want 0", bad);
    end
    cmp_count++;
    if (n != ENTRIES) begin
      fail_count++; $display("FAIL midinit_len: got %0d cycles want %0d", n, ENTRIES);
    end
    for (int t = 0; t < NT; t++) begin
      set_pred(t, int'($urandom_range(0, 15)));
      #1;
      cmp_count++;
      if (o_pred_ghr !== 4'h0 || o_pred_taken !== 1'b1) begin
        fail_count++; $display("FAIL post_init_t%0d: got ghr %0h taken %0b want ghr 0 taken 1",
                               t, o_pred_ghr, o_pred_taken);
      end
      idle();
    end
  endtask

  task automatic test_random();
    int pt, ppc;
    for (int k = 0; k < 400; k++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        pt  = int'($urandom_range(0, 1));
        ppc = int'($urandom_range(0, 15));
        set_pred(pt, ppc);
      end
      if ($urandom_range(0, 2) != 0) begin
        set_res(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 3) == 0));
      end
      #1;
      if (i_pred_valid) begin
        cmp_count++;
        if (o_pred_taken !== exp_taken(pt, ppc) || o_pred_ghr !== 4'(exp_ghr(pt))) begin
          fail_count++;
          $display("FAIL rand_pred%0d: got taken %0b ghr %0h want taken %0b ghr %0h", k,
                   o_pred_taken, o_pred_ghr, exp_taken(pt, ppc), exp_ghr(pt));
        end
      end
      tick();
    end
    idle();
    cmp_count++;
    if (o_ready !== 1'b1) begin
      fail_count++; $display("FAIL rand_ready: got %0b want 1", o_ready);
    end
  endtask

`ifdef GSHARE_STATS_EN
  task automatic test_stats();
    int n;
    i_Reset = 1'b1;
    idle();
    tick();
    i_Reset = 1'b0;
    n = 0;
    while (!o_ready && n < 100) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      set_pred(1, int'($urandom_range(0, 15)));
      tick();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      set_res(1, int'($urandom_range(0, 15)), 0, 1'($urandom), 1'b1);
      tick();
    end
    idle();
    cmp_count++;
    if (o_stat_pred[63:32] !== 32'd5 || o_stat_pred[63:32] !== 32'(m_stat_pred[1])) begin
      fail_count++; $display("FAIL stat_pred_t1: got %0d want 5", o_stat_pred[63:32]);
    end
    cmp_count++;
    if (o_stat_mispred[63:32] !== 32'd2) begin
      fail_count++; $display("FAIL stat_mis_t1: got %0d want 2", o_stat_mispred[63:32]);
    end
    cmp_count++;
    if (o_stat_pred[31:0] !== 32'd0 || o_stat_mispred[31:0] !== 32'd0) begin
      fail_count++; $display("FAIL stat_t0: got %0d/%0d want 0/0", o_stat_pred[31:0],
                             o_stat_mispred[31:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pred_shift();
    test_saturate();
    test_repair();
    test_reset_mid_init();
    test_random();
`ifdef GSHARE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
